// File: rtl/icache_pkg.sv
// Shared types and width helpers for the set-associative instruction cache.
// Widths are derived from the geometry parameters of the instantiating cache.
package icache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_REFILL_AR,
    S_REFILL_R,
    S_BYPASS_AR,
    S_BYPASS_R,
    S_RESP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_SIZE_WORD = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  function automatic int offset_w(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic int word_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int index_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int sets, input int line_words);
    return 32 - offset_w(line_words) - index_w(sets);
  endfunction

  function automatic int way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/icache_way.sv
// One way of the instruction cache: per-set valid bit, tag and line storage.
// All ports address the same set, since the cache works on one request at a time.
module icache_way
  import icache_pkg::*;
#(
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4,
  parameter int TAG_W      = 24,
  parameter int IDX_W      = 4,
  parameter int WORD_W     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [IDX_W-1:0]  idx,
  input  logic [TAG_W-1:0]  tag,
  input  logic [WORD_W-1:0] rd_word,
  output logic              valid,
  output logic              hit,
  output logic [31:0]       rdata,
  input  logic              inval_en,
  input  logic              wr_en,
  input  logic [WORD_W-1:0] wr_word,
  input  logic [31:0]       wr_data,
  input  logic              fill_en
);

  logic [SETS-1:0] valid_q;
  logic [TAG_W-1:0] tag_mem [SETS];
  logic [31:0] data_mem [SETS*LINE_WORDS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (inval_en) begin
      valid_q[idx] <= 1'b0;
    end else if (fill_en) begin
      valid_q[idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[idx] <= tag;
    end
    if (wr_en) begin
      data_mem[{idx, wr_word}] <= wr_data;
    end
  end

  assign valid = valid_q[idx];
  assign hit   = valid_q[idx] && (tag_mem[idx] == tag);
  assign rdata = data_mem[{idx, rd_word}];

endmodule

// File: rtl/icache_sa.sv
// N-way set-associative instruction cache with AXI4 INCR burst refill,
// fence.i flush, read-error propagation and an uncached bypass window.
module icache_sa
  import icache_pkg::*;
#(
  parameter int          WAYS        = 2,
  parameter int          SETS        = 16,
  parameter int          LINE_WORDS  = 4,
  parameter logic [31:0] BYPASS_BASE = 32'h0f00_0000,
  parameter logic [31:0] BYPASS_SIZE = 32'h0100_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_arvalid_i,
  output logic        cpu_arready_o,
  input  logic [31:0] cpu_araddr_i,
  output logic        cpu_rvalid_o,
  input  logic        cpu_rready_i,
  output logic [31:0] cpu_rdata_o,
  output logic [1:0]  cpu_rresp_o,
  input  logic        flush_i,
  output logic        axi_arvalid_o,
  input  logic        axi_arready_i,
  output logic [31:0] axi_araddr_o,
  output logic [7:0]  axi_arlen_o,
  output logic [2:0]  axi_arsize_o,
  output logic [1:0]  axi_arburst_o,
  input  logic        axi_rvalid_i,
  output logic        axi_rready_o,
  input  logic [31:0] axi_rdata_i,
  input  logic [1:0]  axi_rresp_i,
  input  logic        axi_rlast_i,
  output logic        hit_o
);

  localparam int OFF_W  = offset_w(LINE_WORDS);
  localparam int WORD_W = word_w(LINE_WORDS);
  localparam int IDX_W  = index_w(SETS);
  localparam int TAG_W  = tag_w(SETS, LINE_WORDS);
  localparam int WAY_W  = way_w(WAYS);

  state_t state;

  logic [31:0]       req_addr;
  logic [31:0]       araddr_q;
  logic [7:0]        arlen_q;
  logic [WORD_W-1:0] beat_cnt;
  logic [WAY_W-1:0]  victim;
  logic              err_flag;
  logic [1:0]        err_code;
  logic [31:0]       rdata_q;
  logic [1:0]        rresp_q;
  logic              hit_q;
  logic              flush_pending;

  // LRU bit when WAYS==2, round-robin pointer when WAYS>2.
  logic [WAY_W-1:0] repl [SETS];

  logic [WORD_W-1:0] req_word;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;

  assign req_word = req_addr[OFF_W-1:2];
  assign req_idx  = req_addr[OFF_W+IDX_W-1:OFF_W];
  assign req_tag  = req_addr[31:OFF_W+IDX_W];

  logic [WAYS-1:0] way_hit;
  logic [WAYS-1:0] way_valid;
  logic [31:0]     way_rdata [WAYS];

  logic              flush_now;
  logic              is_bypass;
  logic              any_hit;
  logic [WAY_W-1:0]  hit_way;
  logic [31:0]       hit_rdata;
  logic [WAY_W-1:0]  victim_sel;
  logic              beat_fire;
  logic              last_fire;
  logic              beat_err;
  logic              fill_err;
  logic [1:0]        fill_code;

  assign flush_now = (state == S_IDLE) && (flush_i || flush_pending);
  assign is_bypass = ({1'b0, cpu_araddr_i} >= {1'b0, BYPASS_BASE}) &&
                     ({1'b0, cpu_araddr_i} <  ({1'b0, BYPASS_BASE} + {1'b0, BYPASS_SIZE}));

  assign beat_fire = (state == S_REFILL_R) && axi_rvalid_i;
  assign last_fire = beat_fire && axi_rlast_i;
  assign beat_err  = (axi_rresp_i != RESP_OKAY);

  // A last beat that arrives before the final word is an error even if it reports OKAY.
  always_comb begin
    fill_err  = err_flag || beat_err || (beat_cnt != WORD_W'(LINE_WORDS - 1));
    fill_code = RESP_SLVERR;
    if (err_flag) begin
      fill_code = err_code;
    end else if (beat_err) begin
      fill_code = axi_rresp_i;
    end
  end

  always_comb begin
    any_hit   = |way_hit;
    hit_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_hit[w]) begin
        hit_way = WAY_W'(w);
      end
    end
    hit_rdata = way_rdata[hit_way];
  end

  // Empty ways are filled first, lowest index winning; otherwise defer to the replacement state.
  always_comb begin
    logic found;
    found      = 1'b0;
    victim_sel = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!way_valid[w] && !found) begin
        victim_sel = WAY_W'(w);
        found      = 1'b1;
      end
    end
    if (!found && WAYS > 1) begin
      victim_sel = repl[req_idx];
    end
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_way #(
      .SETS       (SETS),
      .LINE_WORDS (LINE_WORDS),
      .TAG_W      (TAG_W),
      .IDX_W      (IDX_W),
      .WORD_W     (WORD_W)
    ) u_way (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush_now),
      .idx      (req_idx),
      .tag      (req_tag),
      .rd_word  (req_word),
      .valid    (way_valid[w]),
      .hit      (way_hit[w]),
      .rdata    (way_rdata[w]),
      .inval_en ((state == S_LOOKUP) && !any_hit && (victim_sel == WAY_W'(w))),
      .wr_en    (beat_fire && (victim == WAY_W'(w))),
      .wr_word  (beat_cnt),
      .wr_data  (axi_rdata_i),
      .fill_en  (last_fire && !fill_err && (victim == WAY_W'(w)))
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      req_addr      <= '0;
      araddr_q      <= '0;
      arlen_q       <= '0;
      beat_cnt      <= '0;
      victim        <= '0;
      err_flag      <= 1'b0;
      err_code      <= RESP_OKAY;
      rdata_q       <= '0;
      rresp_q       <= RESP_OKAY;
      hit_q         <= 1'b0;
      flush_pending <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        repl[s] <= '0;
      end
    end else begin
      hit_q <= 1'b0;
      if (flush_i && state != S_IDLE) begin
        flush_pending <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (flush_now) begin
            flush_pending <= 1'b0;
          end else if (cpu_arvalid_i) begin
            req_addr <= cpu_araddr_i;
            if (is_bypass) begin
              araddr_q <= cpu_araddr_i;
              arlen_q  <= 8'd0;
              state    <= S_BYPASS_AR;
            end else begin
              state <= S_LOOKUP;
            end
          end
        end
        S_LOOKUP: begin
          if (any_hit) begin
            hit_q   <= 1'b1;
            rdata_q <= hit_rdata;
            rresp_q <= RESP_OKAY;
            if (WAYS == 2) begin
              repl[req_idx] <= ~hit_way;
            end
            state <= S_RESP;
          end else begin
            victim   <= victim_sel;
            araddr_q <= {req_addr[31:OFF_W], {OFF_W{1'b0}}};
            arlen_q  <= 8'(LINE_WORDS - 1);
            beat_cnt <= '0;
            err_flag <= 1'b0;
            err_code <= RESP_OKAY;
            state    <= S_REFILL_AR;
          end
        end
        S_REFILL_AR: begin
          if (axi_arready_i) begin
            state <= S_REFILL_R;
          end
        end
        S_REFILL_R: begin
          if (axi_rvalid_i) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == req_word) begin
              rdata_q <= axi_rdata_i;
            end
            if (beat_err && !err_flag) begin
              err_flag <= 1'b1;
              err_code <= axi_rresp_i;
            end
            if (axi_rlast_i) begin
              rresp_q <= fill_err ? fill_code : RESP_OKAY;
              if (!fill_err) begin
                if (WAYS == 2) begin
                  repl[req_idx] <= ~victim;
                end else if (WAYS > 2) begin
                  repl[req_idx] <= repl[req_idx] + 1'b1;
                end
              end
              state <= S_RESP;
            end
          end
        end
        S_BYPASS_AR: begin
          if (axi_arready_i) begin
            state <= S_BYPASS_R;
          end
        end
        S_BYPASS_R: begin
          if (axi_rvalid_i) begin
            rdata_q <= axi_rdata_i;
            rresp_q <= axi_rresp_i;
            state   <= S_RESP;
          end
        end
        S_RESP: begin
          if (cpu_rready_i) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cpu_arready_o = (state == S_IDLE) && !flush_i && !flush_pending && !rst;
  assign cpu_rvalid_o  = (state == S_RESP);
  assign cpu_rdata_o   = rdata_q;
  assign cpu_rresp_o   = rresp_q;
  assign axi_arvalid_o = (state == S_REFILL_AR) || (state == S_BYPASS_AR);
  assign axi_araddr_o  = araddr_q;
  assign axi_arlen_o   = arlen_q;
  assign axi_arsize_o  = AXI_SIZE_WORD;
  assign axi_arburst_o = AXI_BURST_INCR;
  assign axi_rready_o  = (state == S_REFILL_R) || (state == S_BYPASS_R);
  assign hit_o         = hit_q;

endmodule

// File: tb/tb_icache_sa.sv
// Self-checking bench for icache_sa: AXI memory model plus a scoreboard of
// expected fetch responses, with hit and AR counts tracked per fetch.
module tb_icache_sa;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_arvalid_i;
  logic        cpu_arready_o;
  logic [31:0] cpu_araddr_i;
  logic        cpu_rvalid_o;
  logic        cpu_rready_i;
  logic [31:0] cpu_rdata_o;
  logic [1:0]  cpu_rresp_o;
  logic        flush_i;
  logic        axi_arvalid_o;
  logic        axi_arready_i;
  logic [31:0] axi_araddr_o;
  logic [7:0]  axi_arlen_o;
  logic [2:0]  axi_arsize_o;
  logic [1:0]  axi_arburst_o;
  logic        axi_rvalid_i;
  logic        axi_rready_o;
  logic [31:0] axi_rdata_i;
  logic [1:0]  axi_rresp_i;
  logic        axi_rlast_i;
  logic        hit_o;

  icache_sa dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_arvalid_i (cpu_arvalid_i),
    .cpu_arready_o (cpu_arready_o),
    .cpu_araddr_i  (cpu_araddr_i),
    .cpu_rvalid_o  (cpu_rvalid_o),
    .cpu_rready_i  (cpu_rready_i),
    .cpu_rdata_o   (cpu_rdata_o),
    .cpu_rresp_o   (cpu_rresp_o),
    .flush_i       (flush_i),
    .axi_arvalid_o (axi_arvalid_o),
    .axi_arready_i (axi_arready_i),
    .axi_araddr_o  (axi_araddr_o),
    .axi_arlen_o   (axi_arlen_o),
    .axi_arsize_o  (axi_arsize_o),
    .axi_arburst_o (axi_arburst_o),
    .axi_rvalid_i  (axi_rvalid_i),
    .axi_rready_o  (axi_rready_o),
    .axi_rdata_i   (axi_rdata_i),
    .axi_rresp_i   (axi_rresp_i),
    .axi_rlast_i   (axi_rlast_i),
    .hit_o         (hit_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t sb [$];

  int checks = 0;
  int errors = 0;
  int hit_count = 0;
  int ar_count = 0;
  int ar_delay = 0;
  int err_beat = -1;
  logic [1:0]  err_code = 2'b00;
  logic [31:0] last_araddr = '0;
  logic [7:0]  last_arlen = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5C3_5A3C;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (hit_o === 1'b1) hit_count++;
  end

  // AXI memory: optional AR stall with stability checks, then len+1 beats.
  initial begin
    logic [31:0] a;
    logic [7:0]  l;
    axi_arready_i = 1'b0;
    axi_rvalid_i  = 1'b0;
    axi_rdata_i   = '0;
    axi_rresp_i   = 2'b00;
    axi_rlast_i   = 1'b0;
    forever begin
      @(negedge clk);
      if (axi_arvalid_o === 1'b1) begin
        a = axi_araddr_o;
        l = axi_arlen_o;
        ar_count++;
        last_araddr = a;
        last_arlen  = l;
        for (int d = 0; d < ar_delay; d++) begin
          @(negedge clk);
          checkOutput("ar_hold_valid", 32'(axi_arvalid_o), 32'd1);
          checkOutput("ar_hold_addr", axi_araddr_o, a);
          checkOutput("ar_hold_len", 32'(axi_arlen_o), 32'(l));
        end
        axi_arready_i = 1'b1;
        @(posedge clk);
        #1 axi_arready_i = 1'b0;
        for (int b = 0; b <= int'(l); b++) begin
          @(negedge clk);
          axi_rvalid_i = 1'b1;
          axi_rdata_i  = mem_word(a + 32'(4 * b));
          axi_rresp_i  = (b == err_beat) ? err_code : 2'b00;
          axi_rlast_i  = (b == int'(l));
          checkOutput("r_ready", 32'(axi_rready_o), 32'd1);
          @(posedge clk);
          #1;
          axi_rvalid_i = 1'b0;
          axi_rlast_i  = 1'b0;
          axi_rresp_i  = 2'b00;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] addr, input logic [1:0] resp,
                               input int exp_hits, input int exp_ars, input int hold,
                               input bit with_flush, input bit flush_refill);
    exp_t e;
    int h0, a0, n, lat;
    logic [31:0] d;
    logic [1:0]  r;
    e.data = mem_word(addr);
    e.resp = resp;
    sb.push_back(e);
    h0 = hit_count;
    a0 = ar_count;
    @(negedge clk);
    cpu_arvalid_i = 1'b1;
    cpu_araddr_i  = addr;
    if (with_flush) begin
      flush_i = 1'b1;
      #1 checkOutput("flush_arready", 32'(cpu_arready_o), 32'd0);
      @(posedge clk);
      #1 flush_i = 1'b0;
    end
    n = 0;
    while (cpu_arready_o !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checkOutput("arready_timeout", 32'd0, 32'd1);
      cpu_arvalid_i = 1'b0;
      void'(sb.pop_front());
      return;
    end
    @(posedge clk);
    #1 cpu_arvalid_i = 1'b0;
    if (flush_refill) begin
      n = 0;
      @(negedge clk);
      while (axi_rready_o !== 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
      flush_i = 1'b1;
      @(posedge clk);
      #1 flush_i = 1'b0;
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (cpu_rvalid_o !== 1'b1 && lat < 300);
    if (cpu_rvalid_o !== 1'b1) begin
      checkOutput("rvalid_timeout", 32'd0, 32'd1);
      void'(sb.pop_front());
      return;
    end
    if (exp_hits > 0) checkOutput("hit_latency", 32'(lat), 32'd2);
    d = cpu_rdata_o;
    r = cpu_rresp_o;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput("hold_rvalid", 32'(cpu_rvalid_o), 32'd1);
      checkOutput("hold_rdata", cpu_rdata_o, d);
      checkOutput("hold_rresp", 32'(cpu_rresp_o), 32'(r));
      checkOutput("hold_arready", 32'(cpu_arready_o), 32'd0);
    end
    cpu_rready_i = 1'b1;
    e = sb.pop_front();
    checkOutput("rdata", cpu_rdata_o, e.data);
    checkOutput("rresp", 32'(cpu_rresp_o), 32'(e.resp));
    @(posedge clk);
    #1 cpu_rready_i = 1'b0;
    @(negedge clk);
    checkOutput("hit_pulses", 32'(hit_count - h0), 32'(exp_hits));
    checkOutput("ar_issued", 32'(ar_count - a0), 32'(exp_ars));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    cpu_arvalid_i = 1'b0;
    cpu_araddr_i  = '0;
    cpu_rready_i  = 1'b0;
    flush_i       = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_arready", 32'(cpu_arready_o), 32'd0);
    checkOutput("rst_rvalid", 32'(cpu_rvalid_o), 32'd0);
    checkOutput("rst_arvalid", 32'(axi_arvalid_o), 32'd0);
    checkOutput("rst_rready", 32'(axi_rready_o), 32'd0);
    checkOutput("rst_hit", 32'(hit_o), 32'd0);
    checkOutput("rst_arsize", 32'(axi_arsize_o), 32'd2);
    checkOutput("rst_arburst", 32'(axi_arburst_o), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_arready", 32'(cpu_arready_o), 32'd1);

    $display("[TB] cold miss and hit");
    ar_delay = 3;
    applyStimulus(32'h8000_0008, 2'b00, 0, 1, 0, 0, 0);
    checkOutput("miss_araddr", last_araddr, 32'h8000_0000);
    checkOutput("miss_arlen", 32'(last_arlen), 32'd3);
    ar_delay = 0;
    applyStimulus(32'h8000_000C, 2'b00, 1, 0, 5, 0, 0);

    $display("[TB] two-way replacement");
    applyStimulus(32'h8000_0100, 2'b00, 0, 1, 0, 0, 0);
    applyStimulus(32'h8000_0000, 2'b00, 1, 0, 0, 0, 0);
    applyStimulus(32'h8000_0200, 2'b00, 0, 1, 0, 0, 0);
    applyStimulus(32'h8000_0004, 2'b00, 1, 0, 0, 0, 0);
    applyStimulus(32'h8000_0104, 2'b00, 0, 1, 0, 0, 0);

    $display("[TB] bypass window");
    applyStimulus(32'h0f00_0010, 2'b00, 0, 1, 0, 0, 0);
    checkOutput("byp_araddr", last_araddr, 32'h0f00_0010);
    checkOutput("byp_arlen", 32'(last_arlen), 32'd0);
    applyStimulus(32'h0f00_0010, 2'b00, 0, 1, 0, 0, 0);
    applyStimulus(32'h0fff_fffc, 2'b00, 0, 1, 0, 0, 0);
    checkOutput("byp_top_araddr", last_araddr, 32'h0fff_fffc);
    applyStimulus(32'h1000_0004, 2'b00, 0, 1, 0, 0, 0);
    checkOutput("above_byp_araddr", last_araddr, 32'h1000_0000);
    checkOutput("above_byp_arlen", 32'(last_arlen), 32'd3);
    applyStimulus(32'h1000_0008, 2'b00, 1, 0, 0, 0, 0);

    $display("[TB] flush");
    applyStimulus(32'h8000_0000, 2'b00, 0, 1, 0, 1, 0);
    applyStimulus(32'h8000_0100, 2'b00, 0, 1, 0, 0, 1);
    applyStimulus(32'h8000_0100, 2'b00, 0, 1, 0, 0, 0);
    applyStimulus(32'h8000_0000, 2'b00, 0, 1, 0, 0, 0);

    $display("[TB] refill error");
    err_beat = 1;
    err_code = 2'b10;
    applyStimulus(32'h8000_0308, 2'b10, 0, 1, 0, 0, 0);
    err_beat = -1;
    applyStimulus(32'h8000_030C, 2'b00, 0, 1, 0, 0, 0);
    applyStimulus(32'h8000_0300, 2'b00, 1, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
